// File: rtl/dsp_ctrl_pkg.sv
// Shared encodings and legality rule for the DSP48E1 operand-mux control path.
// x_mux, y_mux, z_mux and opmode_ctrl all take their select meanings from here.
package dsp_ctrl_pkg;

   localparam int OPMODE_W = 7;

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_AB   = 2'b11
   } x_sel_e;

   typedef enum logic [1:0] {
      Y_ZERO = 2'b00,
      Y_M    = 2'b01,
      Y_ONES = 2'b10,
      Y_C    = 2'b11
   } y_sel_e;

   typedef enum logic [2:0] {
      Z_ZERO   = 3'b000,
      Z_PCIN   = 3'b001,
      Z_P      = 3'b010,
      Z_C      = 3'b011,
      Z_PMACC  = 3'b100,
      Z_PCIN17 = 3'b101,
      Z_P17    = 3'b110,
      Z_RSVD   = 3'b111
   } z_sel_e;

   // The multiplier produces two partial products, so M must feed X and Y together.
   function automatic logic opmode_legal(input logic [OPMODE_W-1:0] op);
      logic m_on_x;
      logic m_on_y;
      m_on_x = (op[1:0] == X_M);
      m_on_y = (op[3:2] == Y_M);
      return !((m_on_x ^ m_on_y) || (op[6:4] == Z_RSVD));
   endfunction

endpackage

// File: rtl/ctrl_reg.sv
// Generic DSP48E1 control-pin register: async reset, sync reset, clock enable,
// and an optional combinational bypass. Shared by OPMODE, ALUMODE and CARRYINSEL.
module ctrl_reg #(
   parameter int WIDTH = 7,
   parameter int REG   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rst,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
      end else if (rst) begin
         r <= '0;
      end else if (ce) begin
         r <= d;
      end
   end

   // In bypass mode the flop is left unloaded and optimised away.
   assign q = (REG != 0) ? r : d;

endmodule

// File: rtl/opmode_ctrl.sv
// OPMODE register, decode and legality enforcement for the DSP48E1 X/Y/Z muxes,
// with invalid-opmode reporting (level, edge pulse, sticky flag, saturating count).
module opmode_ctrl
   import dsp_ctrl_pkg::*;
#(
   parameter int OPMODEREG = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rstctrl,
   input  logic                 cectrl,
   input  logic [6:0]           opmode_in,
   input  logic                 err_clr,
   output logic [6:0]           opmode_q,
   output logic [1:0]           x_sel,
   output logic [1:0]           y_sel,
   output logic [2:0]           z_sel,
   output logic                 opmode_valid,
   output logic                 invalid_pulse,
   output logic                 err_sticky,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic valid;
   logic prev_valid;

   ctrl_reg #(
      .WIDTH(OPMODE_W),
      .REG  (OPMODEREG)
   ) u_opmode_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .rst  (rstctrl),
      .ce   (cectrl),
      .d    (opmode_in),
      .q    (opmode_q)
   );

   assign valid        = opmode_legal(opmode_q);
   assign opmode_valid = valid;

   // Illegal combinations park every mux on its zero input.
   assign x_sel = valid ? opmode_q[1:0] : X_ZERO;
   assign y_sel = valid ? opmode_q[3:2] : Y_ZERO;
   assign z_sel = valid ? opmode_q[6:4] : Z_ZERO;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid    <= 1'b1;
         invalid_pulse <= 1'b0;
      end else begin
         prev_valid    <= valid;
         invalid_pulse <= prev_valid && !valid;
      end
   end

   // A clear coinciding with an invalid cycle restarts the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
      end else if (err_clr) begin
         err_sticky <= !valid;
         err_count  <= valid ? '0 : ERR_CNT_W'(1);
      end else if (!valid) begin
         err_sticky <= 1'b1;
         if (err_count != '1) begin
            err_count <= err_count + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/opmode_ctrl.md
Name: opmode_ctrl

Overview:
Control-side producer for the DSP48E1 operand muxes. It registers the 7-bit OPMODE, decodes it into the X select (opmode[1:0]), Y select (opmode[3:2]) and Z select (opmode[6:4]), and enforces legal combinations. Illegal opmodes force safe all-zero selects and are reported through a validity flag, an edge pulse, a sticky flag and a saturating error counter. It sits between the control input pins and the x_mux, y_mux and z_mux select inputs.

Parameters:
OPMODEREG, 1, 1 = OPMODE registered (one-cycle latency); 0 = combinational bypass.
ERR_CNT_W, 8, width of the saturating invalid-cycle counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
rstctrl  input  1  synchronous, active-high reset of the OPMODE register only
cectrl  input  1  clock enable of the OPMODE register
opmode_in  input  7  raw OPMODE
err_clr  input  1  synchronous clear of err_sticky and err_count
opmode_q  output  7  effective OPMODE (register output, or opmode_in when OPMODEREG=0)
x_sel  output  2  X mux select: 00 = 0, 01 = M, 10 = P, 11 = A:B
y_sel  output  2  Y mux select: 00 = 0, 01 = M, 10 = all-ones, 11 = C
z_sel  output  3  Z mux select (opmode[6:4])
opmode_valid  output  1  1 when opmode_q is legal
invalid_pulse  output  1  one-cycle pulse on a valid-to-invalid transition
err_sticky  output  1  set on any invalid cycle, held until err_clr
err_count  output  ERR_CNT_W  saturating count of invalid cycles

Behaviour:
- rst_n low (asynchronous): OPMODE register = 7'b0. invalid_pulse, err_sticky and err_count = 0. Previous-valid tracker = 1. Outputs therefore settle to opmode_q = 0, all selects 0, opmode_valid = 1.
- OPMODE register (OPMODEREG=1), per clock edge, in priority order:
  - rstctrl = 1: clear to 0.
  - else cectrl = 1: load opmode_in.
  - else: hold.
  - Latency from opmode_in to selects: 1 cycle.
- OPMODEREG=0: opmode_q = opmode_in. rstctrl and cectrl are ignored. Selects are combinational from the input.
- Legality is combinational on opmode_q. The opmode is invalid when either holds:
  - (opmode_q[1:0] == 2'b01) XOR (opmode_q[3:2] == 2'b01). M must drive X and Y together.
  - opmode_q[6:4] == 3'b111 (reserved).
- opmode_valid = !invalid.
- Select outputs:
  - valid: x_sel = opmode_q[1:0], y_sel = opmode_q[3:2], z_sel = opmode_q[6:4].
  - invalid: x_sel, y_sel and z_sel = 0.
  - opmode_q always shows the raw value.
- invalid_pulse: registered. High for exactly one cycle, in the cycle after the first invalid cycle following a valid cycle. A continuously invalid stream gives a single pulse.
- err_sticky and err_count update each clock edge:
  - err_clr = 1 and invalid in the same cycle: count = 1, sticky = 1. The new error is not lost.
  - err_clr = 1 and valid: count = 0, sticky = 0.
  - err_clr = 0 and invalid: sticky = 1; count increments and saturates at all-ones (no wrap).
  - err_clr = 0 and valid: both hold.
- rstctrl does not clear the error logic. A rstctrl-forced 0 is valid, so the error state just holds.
- rst_n asserted mid-operation: all state clears immediately, with no dependence on clk. Outputs are clean on the first edge after rst_n deasserts.

Decomposition:
- Package dsp_ctrl_pkg, holding:
  - X select encodings: X_ZERO, X_M, X_P, X_AB.
  - Y select encodings: Y_ZERO, Y_M, Y_ONES, Y_C.
  - Z select encodings: Z_ZERO, Z_PCIN, Z_P, Z_C, Z_PMACC, Z_PCIN17, Z_P17, Z_RSVD.
  - An opmode_legal function, so x_mux, y_mux and z_mux share one definition of legality.
- One sub-module: ctrl_reg (parameterised width, async rst_n, sync rst, ce, bypass parameter). Reused later for ALUMODE and CARRYINSEL.

Test Plan:
- Reset: rst_n = 0 with opmode_in = 7'h7F -> opmode_q = 0, all selects 0, opmode_valid = 1, err_count = 0, err_sticky = 0.
- Legal load (OPMODEREG=1): cectrl = 1, opmode_in = 7'b0000101 -> next cycle x_sel = 01, y_sel = 01, z_sel = 000, valid = 1. Then opmode_in = 7'b0101111 -> x_sel = 11, y_sel = 11, z_sel = 010.
- Illegal opmode: opmode_in = 7'b0000001 held for 3 cycles -> selects 0, opmode_valid = 0, one invalid_pulse, err_count = 3, err_sticky = 1. Repeat with opmode_in = 7'b1110000 (reserved Z) and check the same response.
- Enables and resets: cectrl = 0 with opmode_in changing -> opmode_q holds. rstctrl = 1 with cectrl = 1 -> opmode_q = 0 next cycle. With OPMODEREG=0 -> selects follow opmode_in the same cycle.
- Counter limits: invalid held for 300 cycles with ERR_CNT_W = 8 -> err_count = 255 (no wrap). err_clr on an invalid cycle -> err_count = 1, err_sticky = 1. err_clr on a valid cycle -> both 0.
- Async reset: rst_n pulsed low between clock edges during an invalid stream -> all outputs return to reset values immediately, with no clock edge needed.
